// File: rtl/periph_rx_arbiter_pkg.sv
// Shared constants and types for the peripheral RX arbiter.
// Channel count and word width default to the board-level peripheral and USB packet sizes.
package lycan_globals;

  localparam int num_peripherals  = 8;
  localparam int usb_packet_width = 32;
  localparam int arb_burst_max    = 16;

  typedef enum logic {
    ARB    = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

endpackage

// File: rtl/periph_rx_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request at or after ptr, wrapping at N.
// Works for non-power-of-2 N by wrapping the rotated index explicitly.
module rr_picker
  import lycan_globals::*;
#(
  parameter  int N    = 8,
  localparam int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  localparam logic [CH_W:0] N_EXT = (CH_W + 1)'(N);

  logic [N-1:0]    rot;
  logic [CH_W-1:0] src_idx [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [CH_W:0] sum;
      assign sum         = {1'b0, ptr} + (CH_W + 1)'(gi);
      assign src_idx[gi] = (sum >= N_EXT) ? CH_W'(sum - N_EXT) : sum[CH_W-1:0];
      assign rot[gi]     = req[src_idx[gi]];
    end
  endgenerate

  // Scan from the top so the lowest rotated position is the last, winning, assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        idx   = src_idx[i];
      end
    end
  end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Selects one peripheral RX FIFO at a time and streams bounded bursts into a registered
// valid/ready output. Optional urgent-channel preemption: `PERIPH_ARB_PREEMPT_EN.
module periph_rx_arbiter
  import lycan_globals::*;
#(
  parameter  int NUM_CHANNELS = num_peripherals,
  parameter  int DATA_WIDTH   = usb_packet_width,
  parameter  int BURST_MAX    = arb_burst_max,
  localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_l,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]            ch_empty,
  input  logic [NUM_CHANNELS-1:0]            ch_almost_full,
  output logic [NUM_CHANNELS-1:0]            ch_rden,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CH_W-1:0]                    out_chan,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CH_W-1:0]                    grant,
  output logic                               busy
);

  localparam int              BCW        = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0]  BURST_LAST = BCW'(BURST_MAX - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CHANNELS - 1);

  arb_state_t            state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]        burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_chan_q, out_chan_d;

  logic [DATA_WIDTH-1:0]   ch_word [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] req, urg;
  logic                    urg_found, req_found;
  logic [CH_W-1:0]         urg_idx, req_idx;
  logic                    cur_empty, pop, preempt, burst_done;
  logic [CH_W-1:0]         next_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_word
      assign ch_word[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign req = ~ch_empty;
  assign urg = req & ch_almost_full;

  rr_picker #(.N(NUM_CHANNELS)) u_pick_urg (
    .req   (urg),
    .ptr   (rr_ptr_q),
    .found (urg_found),
    .idx   (urg_idx)
  );

  rr_picker #(.N(NUM_CHANNELS)) u_pick_req (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (req_found),
    .idx   (req_idx)
  );

  assign cur_empty  = ch_empty[grant_q];
  assign pop        = (state_q == STREAM) && !cur_empty && (!out_valid_q || out_ready);
  assign burst_done = pop && (burst_cnt_q == BURST_LAST);
  assign next_ptr   = (grant_q == CH_LAST) ? '0 : grant_q + 1'b1;

`ifdef PERIPH_ARB_PREEMPT_EN
  logic [NUM_CHANNELS-1:0] grant_onehot;
  logic                    cur_urgent;
  assign grant_onehot = NUM_CHANNELS'(1) << grant_q;
  assign cur_urgent   = ch_almost_full[grant_q] && !cur_empty;
  // Another channel going urgent cuts a normal burst short after this cycle's pop.
  assign preempt      = !cur_urgent && |(urg & ~grant_onehot);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ch_rden     = '0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB: begin
        if (urg_found) begin
          grant_d     = urg_idx;
          burst_cnt_d = '0;
          state_d     = STREAM;
        end else if (req_found) begin
          grant_d     = req_idx;
          burst_cnt_d = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        // A pop overrides the consume-clear above, so pop+consume keeps out_valid high.
        if (pop) begin
          ch_rden[grant_q] = 1'b1;
          out_data_d       = ch_word[grant_q];
          out_chan_d       = grant_q;
          out_valid_d      = 1'b1;
          burst_cnt_d      = burst_cnt_q + 1'b1;
        end
        if (burst_done || cur_empty || preempt) begin
          state_d     = ARB;
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ARB;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q == STREAM);

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// Directed bench for periph_rx_arbiter: FWFT FIFO models feed the DUT, consumed words are logged
// and compared with hand-derived sequences. Preemption checks follow `PERIPH_ARB_PREEMPT_EN.
module tb_periph_rx_arbiter;
  import lycan_globals::*;

  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int BM  = 16;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst_l;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_empty;
  logic [NCH-1:0]    ch_almost_full;
  logic [NCH-1:0]    ch_rden;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     grant;
  logic              busy;

  periph_rx_arbiter #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .ch_data        (ch_data),
    .ch_empty       (ch_empty),
    .ch_almost_full (ch_almost_full),
    .ch_rden        (ch_rden),
    .out_data       (out_data),
    .out_chan       (out_chan),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .grant          (grant),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int pop_cnt = 0;

  logic [DW-1:0] fifo_q [NCH][$];
  logic [DW-1:0] got_data [$];
  logic [CW-1:0] got_chan [$];
  int            got_cyc  [$];

  logic [NCH-1:0] s_rden;
  logic [DW-1:0]  s_data;
  logic [CW-1:0]  s_chan;
  logic           s_valid;
  logic [CW-1:0]  s_grant;
  logic           s_busy;

  task automatic drive_fifos();
    for (int c = 0; c < NCH; c++) begin
      ch_empty[c] = (fifo_q[c].size() == 0);
      ch_data[c*DW +: DW] = (fifo_q[c].size() == 0) ? '0 : fifo_q[c][0];
    end
  endtask

  task automatic push(input int c, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q[c].push_back(base + DW'(i));
    drive_fifos();
  endtask

  // Called at a falling edge; returns at the next falling edge with that cycle's outputs sampled.
  task automatic tick();
    logic [NCH-1:0] r;
    logic           v;
    logic [DW-1:0]  d;
    logic [CW-1:0]  ch;
    #2;
    r  = ch_rden;
    v  = out_valid & out_ready;
    d  = out_data;
    ch = out_chan;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (r[c] && fifo_q[c].size() > 0) begin
        void'(fifo_q[c].pop_front());
        pop_cnt++;
      end
    end
    if (v) begin
      got_data.push_back(d);
      got_chan.push_back(ch);
      got_cyc.push_back(cyc - 1);
      $display("xfer cyc=%0d chan=%0d data=%h", cyc - 1, ch, d);
    end
    drive_fifos();
    @(negedge clk);
    s_rden  = ch_rden;
    s_data  = out_data;
    s_chan  = out_chan;
    s_valid = out_valid;
    s_grant = grant;
    s_busy  = busy;
  endtask

  task automatic do_reset();
    rst_l          = 1'b0;
    ch_almost_full = '0;
    out_ready      = 1'b1;
    for (int c = 0; c < NCH; c++) fifo_q[c].delete();
    drive_fifos();
    tick();
    tick();
    rst_l = 1'b1;
    tick();
    got_data.delete();
    got_chan.delete();
    got_cyc.delete();
    pop_cnt = 0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    out_ready = 1'b1;
    ch_almost_full = '0;
    drive_fifos();
    tick();
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_rden !== '0 || s_busy !== 1'b0 || s_grant !== '0 ||
        s_data !== '0 || s_chan !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b rden=%b busy=%b grant=%0d data=%h chan=%0d, required all 0",
               s_valid, s_rden, s_busy, s_grant, s_data, s_chan);
    end
    rst_l = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (s_rden !== '0 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_grant !== '0) begin
        errors++;
        $display("FAIL idle_empty cycle %0d: rden=%b valid=%b busy=%b grant=%0d, required 0/0/0/0",
                 k, s_rden, s_valid, s_busy, s_grant);
      end
    end
  endtask

  task automatic test_single_channel();
    logic [DW-1:0] w [3];
    do_reset();
    w[0] = 32'hAAAA_0001;
    w[1] = 32'hBBBB_0002;
    w[2] = 32'hCCCC_0003;
    for (int i = 0; i < 3; i++) fifo_q[2].push_back(w[i]);
    drive_fifos();
    tick();
    checks++;
    if (s_grant !== 3'd2 || s_busy !== 1'b1 || s_rden !== 8'h04 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%0d busy=%b rden=%b valid=%b, required 2/1/00000100/0",
               s_grant, s_busy, s_rden, s_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_data !== w[i] || s_chan !== 3'd2) begin
        errors++;
        $display("FAIL single_word%0d: valid=%b data=%h chan=%0d, required 1/%h/2",
                 i, s_valid, s_data, s_chan, w[i]);
      end
    end
    checks++;
    if (s_rden !== '0) begin
      errors++;
      $display("FAIL single_no_pop_when_empty: rden=%b, required 0", s_rden);
    end
    tick();
    checks++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_back_to_arb: busy=%b valid=%b, required 0/0", s_busy, s_valid);
    end
  endtask

  task automatic test_two_channel_bursts();
    logic [DW-1:0] exp_d;
    logic [CW-1:0] exp_c;
    do_reset();
    push(0, 20, 32'h0000_0100);
    push(5, 20, 32'h0500_0100);
    for (int k = 0; k < 300 && got_data.size() < 40; k++) tick();
    checks++;
    if (got_data.size() != 40) begin
      errors++;
      $display("FAIL bursts_count: got %0d words, required 40", got_data.size());
    end else begin
      for (int k = 0; k < 40; k++) begin
        if (k < 16)      begin exp_c = 3'd0; exp_d = 32'h0000_0100 + DW'(k);      end
        else if (k < 32) begin exp_c = 3'd5; exp_d = 32'h0500_0100 + DW'(k - 16); end
        else if (k < 36) begin exp_c = 3'd0; exp_d = 32'h0000_0100 + DW'(k - 16); end
        else             begin exp_c = 3'd5; exp_d = 32'h0500_0100 + DW'(k - 20); end
        checks++;
        if (got_chan[k] !== exp_c || got_data[k] !== exp_d) begin
          errors++;
          $display("FAIL bursts_word%0d: chan=%0d data=%h, required chan=%0d data=%h",
                   k, got_chan[k], got_data[k], exp_c, exp_d);
        end
      end
      checks++;
      if (got_cyc[1] - got_cyc[0] != 1 || got_cyc[16] - got_cyc[15] != 2) begin
        errors++;
        $display("FAIL bursts_spacing: in-burst gap=%0d rearb gap=%0d, required 1 and 2",
                 got_cyc[1] - got_cyc[0], got_cyc[16] - got_cyc[15]);
      end
    end
  endtask

  task automatic test_urgent();
    logic [CW-1:0] exp_c;
    do_reset();
    push(1, 3, 32'h1111_0000);
    push(6, 3, 32'h6666_0000);
    ch_almost_full[6] = 1'b1;
    tick();
    checks++;
    if (s_grant !== 3'd6 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL urgent_first_grant: grant=%0d busy=%b, required 6/1", s_grant, s_busy);
    end
    for (int k = 0; k < 50 && got_data.size() < 6; k++) tick();
    checks++;
    if (got_chan.size() != 6) begin
      errors++;
      $display("FAIL urgent_count: got %0d words, required 6", got_chan.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        exp_c = (k < 3) ? 3'd6 : 3'd1;
        checks++;
        if (got_chan[k] !== exp_c) begin
          errors++;
          $display("FAIL urgent_order%0d: chan=%0d, required %0d", k, got_chan[k], exp_c);
        end
      end
    end

    do_reset();
    push(1, 20, 32'h1111_1000);
    push(6, 2, 32'h6666_1000);
    tick();
    tick();
    tick();
    ch_almost_full[6] = 1'b1;
    tick();
`ifdef PERIPH_ARB_PREEMPT_EN
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_exit: busy=%b, required 0", s_busy);
    end
    tick();
    checks++;
    if (s_grant !== 3'd6 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL preempt_grant: grant=%0d busy=%b, required 6/1", s_grant, s_busy);
    end
`else
    checks++;
    if (s_busy !== 1'b1 || s_grant !== 3'd1) begin
      errors++;
      $display("FAIL no_preempt_hold: busy=%b grant=%0d, required 1/1", s_busy, s_grant);
    end
    tick();
    checks++;
    if (s_busy !== 1'b1 || s_grant !== 3'd1) begin
      errors++;
      $display("FAIL no_preempt_hold2: busy=%b grant=%0d, required 1/1", s_busy, s_grant);
    end
`endif
    for (int k = 0; k < 200 && got_data.size() < 22; k++) tick();
    checks++;
    if (got_data.size() != 22) begin
      errors++;
      $display("FAIL urgent_drain: got %0d words, required 22", got_data.size());
    end
    ch_almost_full = '0;
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    push(3, 6, 32'h3333_0000);
    tick();
    checks++;
    if (s_grant !== 3'd3 || s_rden !== 8'h08) begin
      errors++;
      $display("FAIL stall_first_pop: grant=%0d rden=%b, required 3/00001000", s_grant, s_rden);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_data !== 32'h3333_0000 || s_rden !== '0) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b data=%h rden=%b, required 1/33330000/0",
                 k, s_valid, s_data, s_rden);
      end
    end
    checks++;
    if (pop_cnt != 1) begin
      errors++;
      $display("FAIL stall_pop_count: popped %0d, required 1", pop_cnt);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 50 && got_data.size() < 6; k++) tick();
    checks++;
    if (got_data.size() != 6 || pop_cnt != 6) begin
      errors++;
      $display("FAIL stall_resume_count: got %0d popped %0d, required 6/6", got_data.size(), pop_cnt);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got_data[k] !== 32'h3333_0000 + DW'(k)) begin
          errors++;
          $display("FAIL stall_resume_word%0d: data=%h, required %h", k, got_data[k],
                   32'h3333_0000 + DW'(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(4, 2, 32'h4444_0000);
    for (int k = 0; k < 20 && (got_data.size() < 2 || s_busy); k++) tick();
    push(6, 20, 32'h6666_2000);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (s_valid !== 1'b1 || s_grant !== 3'd6) begin
      errors++;
      $display("FAIL areset_setup: valid=%b grant=%0d, required 1/6", s_valid, s_grant);
    end
    rst_l = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== '0 || ch_rden !== '0 ||
        busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL areset_immediate: valid=%b data=%h chan=%0d rden=%b busy=%b grant=%0d, required all 0",
               out_valid, out_data, out_chan, ch_rden, busy, grant);
    end
    for (int c = 0; c < NCH; c++) fifo_q[c].delete();
    push(2, 3, 32'h2222_0000);
    push(7, 3, 32'h7777_0000);
    tick();
    tick();
    checks++;
    if (s_busy !== 1'b0 || s_rden !== '0) begin
      errors++;
      $display("FAIL areset_held: busy=%b rden=%b, required 0/0", s_busy, s_rden);
    end
    rst_l = 1'b1;
    tick();
    checks++;
    if (s_grant !== 3'd2 || s_busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_rr_restart: grant=%0d busy=%b, required 2/1", s_grant, s_busy);
    end
  endtask

  initial begin
    rst_l          = 1'b0;
    out_ready      = 1'b1;
    ch_almost_full = '0;
    drive_fifos();
    @(negedge clk);
    test_reset();
    test_single_channel();
    test_two_channel_bursts();
    test_urgent();
    test_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
